// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared types and tree-indexing helpers for the pseudo-LRU array
package plru_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // A binary tree over W leaves has W-1 internal nodes.
    function automatic int num_nodes(input int ways);
        return ways - 1;
    endfunction

    // Node i has children 2i+1 (left, dir=0) and 2i+2 (right, dir=1).
    function automatic int child(input int node, input logic dir);
        return 2 * node + 1 + int'(dir);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational tree walk: victim selection and touch update of one set
module plru_tree
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = $clog2(NUM_WAYS),
    parameter int NODES    = num_nodes(NUM_WAYS)
) (
    input  logic [NODES-1:0] i_bits,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAY_W-1:0] o_victim,
    output logic [NODES-1:0] o_bits
);

    int               w_node_v;
    int               w_node_t;
    logic [WAY_W-1:0] w_way_sh;
    logic             w_dir;

    always_comb begin
        o_victim = '0;
        o_bits   = i_bits;
        w_node_v = 0;
        w_node_t = 0;
        w_way_sh = i_way;
        w_dir    = 1'b0;
        // Both walks visit one node per level; the touch walk follows the way's MSB-first path.
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            w_dir    = i_bits[w_node_v[WAY_W-1:0]];
            o_victim = (o_victim << 1) | WAY_W'(w_dir);
            w_node_v = child(w_node_v, w_dir);

            o_bits[w_node_t[WAY_W-1:0]] = ~w_way_sh[WAY_W-1];
            w_node_t = child(w_node_t, w_way_sh[WAY_W-1]);
            w_way_sh = w_way_sh << 1;
        end
    end

endmodule

// File: rtl/plru_array.sv
// rtl/plru_array.sv - tree pseudo-LRU state array with clear sweep; PLRU_BYPASS_EN forwards same-set touches to lookups
module plru_array
    import plru_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    output logic             o_ready,
    input  logic             i_touch_en,
    input  logic [SET_W-1:0] i_touch_set,
    input  logic [WAY_W-1:0] i_touch_way,
    input  logic             i_lookup_en,
    input  logic [SET_W-1:0] i_lookup_set,
    output logic             o_victim_valid,
    output logic [WAY_W-1:0] o_victim_way
);

    localparam int NODES = num_nodes(NUM_WAYS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SET_W-1:0] r_cnt;
    logic [SET_W-1:0] w_cnt_nxt;
    logic             w_clr;
    logic             w_accept;

    logic [NODES-1:0] r_mem [NUM_SETS];
    logic [NODES-1:0] w_touch_rd;
    logic [NODES-1:0] w_touch_wr;
    logic [NODES-1:0] w_lk_bits;
    logic [NODES-1:0] w_lk_bits_unused;
    logic [WAY_W-1:0] w_lk_victim;
    logic [WAY_W-1:0] w_touch_victim_unused;

    logic             r_valid;
    logic [WAY_W-1:0] r_victim;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr       = 1'b0;
        case (r_state)
            INIT: begin
                w_clr     = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == SET_W'(NUM_SETS - 1)) begin
                    w_state_nxt = READY;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = INIT;
        endcase
        if (i_flush) begin
            w_state_nxt = INIT;
            w_cnt_nxt   = '0;
        end
    end

    assign w_accept = (r_state == READY) && !i_flush;
    assign o_ready  = (r_state == READY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= INIT;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_victim <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_accept && i_lookup_en;
            if (w_accept && i_lookup_en) begin
                r_victim <= w_lk_victim;
            end
        end
    end

    // Storage is never reset: the sweep clears it instead.
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_accept && i_touch_en) begin
            r_mem[i_touch_set] <= w_touch_wr;
        end
    end

    assign w_touch_rd = r_mem[i_touch_set];

`ifdef PLRU_BYPASS_EN
    assign w_lk_bits = (i_touch_en && (i_touch_set == i_lookup_set)) ? w_touch_wr : r_mem[i_lookup_set];
`else
    assign w_lk_bits = r_mem[i_lookup_set];
`endif

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_touch_tree (
        .i_bits   (w_touch_rd),
        .i_way    (i_touch_way),
        .o_victim (w_touch_victim_unused),
        .o_bits   (w_touch_wr)
    );

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_lookup_tree (
        .i_bits   (w_lk_bits),
        .i_way    ({WAY_W{1'b0}}),
        .o_victim (w_lk_victim),
        .o_bits   (w_lk_bits_unused)
    );

    assign o_victim_valid = r_valid;
    assign o_victim_way   = r_victim;

endmodule

// File: tb/tb_plru_array.sv
// tb/tb_plru_array.sv - self-checking bench for plru_array (4-, 8- and 2-way instances)
module tb_plru_array;

    localparam int SETS = 64;
    localparam int WAYS = 4;
`ifdef PLRU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       flush, ready, t_en, l_en, v_valid;
    logic [5:0] t_set, l_set;
    logic [1:0] t_way, v_way;

    logic       flush_x;
    logic       ready8, t_en8, l_en8, v_valid8;
    logic [1:0] t_set8, l_set8;
    logic [2:0] t_way8, v_way8;
    logic       ready2, t_en2, l_en2, v_valid2;
    logic [1:0] t_set2, l_set2;
    logic [0:0] t_way2, v_way2;

    plru_array #(.NUM_SETS(SETS), .NUM_WAYS(WAYS)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .o_ready(ready),
        .i_touch_en(t_en), .i_touch_set(t_set), .i_touch_way(t_way),
        .i_lookup_en(l_en), .i_lookup_set(l_set),
        .o_victim_valid(v_valid), .o_victim_way(v_way)
    );

    plru_array #(.NUM_SETS(4), .NUM_WAYS(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush_x), .o_ready(ready8),
        .i_touch_en(t_en8), .i_touch_set(t_set8), .i_touch_way(t_way8),
        .i_lookup_en(l_en8), .i_lookup_set(l_set8),
        .o_victim_valid(v_valid8), .o_victim_way(v_way8)
    );

    plru_array #(.NUM_SETS(4), .NUM_WAYS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush_x), .o_ready(ready2),
        .i_touch_en(t_en2), .i_touch_set(t_set2), .i_touch_way(t_way2),
        .i_lookup_en(l_en2), .i_lookup_set(l_set2),
        .o_victim_valid(v_valid2), .o_victim_way(v_way2)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned stamp    = 0;
    // Reference state: per set, the time each way was last touched (0 = never since clear).
    int unsigned m4 [SETS][8];
    int unsigned m8 [4][8];
    int unsigned m2 [4][8];
    int          last4 = 0, last8 = 0, last2 = 0;

    typedef struct {
        bit te; int ts; int tw; bit le; int ls; int ev; int ew;
    } vec_t;
    vec_t tbl [10];

    // Descend towards the half whose most recent touch is older; untouched ties go left.
    function automatic int model_victim(input int unsigned t [8], input int n);
        int lo, size, half;
        int unsigned ml, mr;
        lo = 0;
        size = n;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (t[lo+i] > ml) ml = t[lo+i];
                if (t[lo+half+i] > mr) mr = t[lo+half+i];
            end
            if (ml > mr) lo += half;
            size = half;
        end
        return lo;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear4();
        foreach (m4[s, w]) m4[s][w] = 0;
    endtask

    task automatic cyc4(input bit te, input int ts, input int tw, input bit le, input int ls,
                        input bit fl, output int ev);
        int unsigned tmp [8];
        bit acc;
        t_en = te; t_set = 6'(ts); t_way = 2'(tw);
        l_en = le; l_set = 6'(ls); flush = fl;
        acc = ready && !fl;
        ev = 0;
        if (acc && le) begin
            tmp = m4[ls];
            if (BYP && te && ts == ls) tmp[tw] = stamp + 1;
            last4 = model_victim(tmp, WAYS);
            ev = 1;
        end
        step();
        if (acc && te) begin
            stamp++;
            m4[ts][tw] = stamp;
        end
        if (fl) clear4();
        t_en = 1'b0; l_en = 1'b0; flush = 1'b0;
    endtask

    task automatic cycn(input int nw, input bit te, input int ts, input int tw, input bit le,
                        input int ls, output int ev, output int ew);
        int unsigned tmp [8];
        bit acc;
        if (nw == 8) begin
            t_en8 = te; t_set8 = 2'(ts); t_way8 = 3'(tw); l_en8 = le; l_set8 = 2'(ls);
            acc = ready8;
            tmp = m8[ls];
        end else begin
            t_en2 = te; t_set2 = 2'(ts); t_way2 = 1'(tw); l_en2 = le; l_set2 = 2'(ls);
            acc = ready2;
            tmp = m2[ls];
        end
        ev = 0;
        if (acc && le) begin
            if (BYP && te && ts == ls) tmp[tw] = stamp + 1;
            if (nw == 8) last8 = model_victim(tmp, 8);
            else last2 = model_victim(tmp, 2);
            ev = 1;
        end
        step();
        if (acc && te) begin
            stamp++;
            if (nw == 8) m8[ts][tw] = stamp;
            else m2[ts][tw] = stamp;
        end
        t_en8 = 1'b0; l_en8 = 1'b0; t_en2 = 1'b0; l_en2 = 1'b0;
        ew = (nw == 8) ? last8 : last2;
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        chk(name, n, SETS);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ev, ew, n;
        flush = 0; t_en = 0; t_set = 0; t_way = 0; l_en = 0; l_set = 0;
        flush_x = 0;
        t_en8 = 0; t_set8 = 0; t_way8 = 0; l_en8 = 0; l_set8 = 0;
        t_en2 = 0; t_set2 = 0; t_way2 = 0; l_en2 = 0; l_set2 = 0;
        clear4();
        foreach (m8[s, w]) m8[s][w] = 0;
        foreach (m2[s, w]) m2[s][w] = 0;

        tbl[0] = '{1'b1, 5, 0, 1'b0, 0, 0, 0};
        tbl[1] = '{1'b0, 0, 0, 1'b1, 5, 1, 2};
        tbl[2] = '{1'b1, 5, 2, 1'b0, 0, 0, 2};
        tbl[3] = '{1'b0, 0, 0, 1'b1, 5, 1, 1};
        tbl[4] = '{1'b0, 0, 0, 1'b1, 6, 1, 0};
        tbl[5] = '{1'b1, 3, 0, 1'b1, 3, 1, BYP ? 2 : 0};
        tbl[6] = '{1'b0, 0, 0, 1'b1, 3, 1, 2};
        tbl[7] = '{1'b0, 0, 0, 1'b0, 0, 0, 2};
        tbl[8] = '{1'b1, 5, 1, 1'b1, 5, 1, BYP ? 3 : 1};
        tbl[9] = '{1'b0, 0, 0, 1'b1, 5, 1, 3};

        step();
        step();
        chk("reset_ready", ready, 0);
        chk("reset_valid", v_valid, 0);
        chk("reset_way", v_way, 0);
        rst = 1'b0;
        count_sweep("por_sweep_len");

        foreach (tbl[i]) begin
            if (i < 3) begin
                cyc4(1'b0, 0, 0, 1'b1, i * 31, 1'b0, ev);
                chk("cleared_valid", v_valid, 1);
                chk("cleared_way", v_way, 0);
            end
        end

        for (int i = 0; i < 10; i++) begin
            cyc4(tbl[i].te, tbl[i].ts, tbl[i].tw, tbl[i].le, tbl[i].ls, 1'b0, ev);
            chk($sformatf("tbl%0d_valid", i), v_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_way", i), v_way, tbl[i].ew);
            chk($sformatf("tbl%0d_model", i), v_way, last4);
        end

        // Restart the sweep, then pull reset when the counter reaches 30.
        cyc4(1'b0, 0, 0, 1'b0, 0, 1'b1, ev);
        repeat (30) cyc4(1'b0, 0, 0, 1'b0, 0, 1'b0, ev);
        chk("flush_hold_way", v_way, 3);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_valid", v_valid, 0);
        chk("midrst_way", v_way, 0);
        step();
        rst = 1'b0;
        last4 = 0; last8 = 0; last2 = 0;
        clear4();
        foreach (m8[s, w]) m8[s][w] = 0;
        foreach (m2[s, w]) m2[s][w] = 0;
        count_sweep("midrst_sweep_len");

        repeat (400) begin
            int ts, ls;
            ts = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
            ls = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
            cyc4(1'($urandom), ts, int'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0), ls, 1'b0, ev);
            chk("rand_valid", v_valid, ev);
            chk("rand_way", v_way, last4);
        end

        repeat (10) begin
            cyc4(1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'b0, 0, 1'b0, ev);
            chk("pre_flush_ready", ready, 1);
        end
        cyc4(1'b1, 7, 1, 1'b1, 7, 1'b1, ev);
        chk("flush_ready", ready, 0);
        chk("flush_valid", v_valid, 0);
        for (int i = 1; i <= SETS; i++) begin
            cyc4(1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(0, 63)), 1'b0, ev);
            chk($sformatf("sweep_ready_c%0d", i), ready, (i == SETS) ? 1 : 0);
            chk("sweep_valid", v_valid, 0);
        end
        for (int s = 0; s < SETS; s++) begin
            cyc4(1'b0, 0, 0, 1'b1, s, 1'b0, ev);
            chk($sformatf("post_flush_set%0d", s), v_way, 0);
            chk("post_flush_valid", v_valid, 1);
        end

        chk("ready8", ready8, 1);
        for (int w = 0; w < 8; w++) cycn(8, 1'b1, 1, w, 1'b0, 0, ev, ew);
        cycn(8, 1'b0, 0, 0, 1'b1, 1, ev, ew);
        chk("w8_all_in_order", v_way8, 0);
        chk("w8_all_model", v_way8, ew);
        cycn(8, 1'b1, 2, 7, 1'b0, 0, ev, ew);
        cycn(8, 1'b1, 2, 3, 1'b0, 0, ev, ew);
        cycn(8, 1'b0, 0, 0, 1'b1, 2, ev, ew);
        chk("w8_seq73", v_way8, ew);
        cycn(8, 1'b1, 2, 0, 1'b1, 2, ev, ew);
        chk("w8_seq730_same_cycle", v_way8, ew);
        cycn(8, 1'b0, 0, 0, 1'b1, 2, ev, ew);
        chk("w8_seq730", v_way8, ew);
        repeat (150) begin
            cycn(8, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 1'($urandom), int'($urandom_range(0, 3)), ev, ew);
            chk("w8_rand_valid", v_valid8, ev);
            chk("w8_rand_way", v_way8, ew);
        end

        chk("ready2", ready2, 1);
        cycn(2, 1'b1, 1, 0, 1'b0, 0, ev, ew);
        cycn(2, 1'b1, 1, 1, 1'b0, 0, ev, ew);
        cycn(2, 1'b0, 0, 0, 1'b1, 1, ev, ew);
        chk("w2_all_in_order", v_way2, 0);
        repeat (100) begin
            cycn(2, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 1'($urandom), int'($urandom_range(0, 3)), ev, ew);
            chk("w2_rand_valid", v_valid2, ev);
            chk("w2_rand_way", v_way2, ew);
        end

        n = n_checks;
        $display("End of test - %0d assertions evaluated, %0d failures", n, n_fail);
        $finish;
    end

endmodule
